// File: rtl/tff_seq_pkg.sv
// Shared types and constants for the toggle-sequence controller.
package tff_seq_pkg;

  localparam int MASK_W = 8;
  localparam int CNT_W  = 8;
  localparam int PER_W  = 4;

  localparam logic [MASK_W-1:0] MASK_ZERO = {MASK_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [PER_W-1:0]  PER_ZERO  = {PER_W{1'b0}};
  localparam logic [PER_W-1:0]  PER_ONE   = {{(PER_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } tff_state_e;

  function automatic logic [MASK_W-1:0] gate_mask(input logic en, input logic [MASK_W-1:0] m);
    return en ? m : MASK_ZERO;
  endfunction

endpackage

// File: rtl/tff_cell.sv
// One-bit T flip-flop built as a D flop with D = T ^ Q.
module tff_cell (
  input  logic clk,
  input  logic reset,
  input  logic t,
  output logic q
);

  logic q_r;
  logic d_s;

  assign d_s = t ^ q_r;

  // toggle state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_r <= 1'b0;
    end else begin
      q_r <= d_s;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/tff_seq_ctrl_chk.sv
// Protocol properties of tff_seq_ctrl outputs; instantiated alongside the controller.
module tff_seq_ctrl_chk
  import tff_seq_pkg::*;
(
  input logic              clk,
  input logic              reset,
  input logic              cmd_ready,
  input logic              busy,
  input logic              done,
  input logic [MASK_W-1:0] t_out
);

  a_ready_not_busy: assert property (@(posedge clk) disable iff (reset) cmd_ready == !busy);
  a_done_in_busy:   assert property (@(posedge clk) disable iff (reset) done |-> busy);
  a_done_single:    assert property (@(posedge clk) disable iff (reset) done |=> !done);
  a_pulse_in_run:   assert property (@(posedge clk) disable iff (reset)
                                     (t_out != MASK_ZERO) |-> (busy && !done && !cmd_ready));

endmodule

// File: rtl/tff_seq_ctrl.sv
// Command-driven pulse sequencer feeding an 8-bit toggle bank.
// Optional abort input enabled by defining TFF_SEQ_ABORT_EN.
module tff_seq_ctrl
  import tff_seq_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [MASK_W-1:0] cmd_mask,
  input  logic [CNT_W-1:0]  cmd_count,
  input  logic [PER_W-1:0]  cmd_period,
`ifdef TFF_SEQ_ABORT_EN
  input  logic              abort,
`endif
  output logic [MASK_W-1:0] t_out,
  output logic [MASK_W-1:0] q,
  output logic              busy,
  output logic              done
);

  tff_state_e        state_r, state_s;
  logic [MASK_W-1:0] mask_r, mask_s;
  logic [PER_W-1:0]  per_r, per_s;
  logic [PER_W-1:0]  timer_r, timer_s;
  logic [CNT_W-1:0]  rem_r, rem_s;
  logic              ready_r, busy_r, done_r;
  logic              abort_s;
  logic              fire_s;

`ifdef TFF_SEQ_ABORT_EN
  assign abort_s = abort;
`else
  assign abort_s = 1'b0;
`endif

  // Pulse is decoded from registered state; abort gates it within the same cycle.
  assign fire_s = (state_r == ST_RUN) && (timer_r == PER_ZERO) && !abort_s;
  assign t_out  = gate_mask(fire_s, mask_r);

  // next-state and datapath update
  always_comb begin
    state_s = state_r;
    mask_s  = mask_r;
    per_s   = per_r;
    timer_s = timer_r;
    rem_s   = rem_r;
    case (state_r)
      ST_IDLE: begin
        if (cmd_valid) begin
          mask_s  = cmd_mask;
          per_s   = cmd_period;
          rem_s   = cmd_count;
          timer_s = cmd_period;
          if (cmd_count == CNT_ZERO) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_RUN;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (abort_s) begin
          state_s = ST_DONE;
        end else if (timer_r == PER_ZERO) begin
          timer_s = per_r;
          rem_s   = rem_r - CNT_ONE;
          if (rem_r == CNT_ONE) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_RUN;
          end
        end else begin
          timer_s = timer_r - PER_ONE;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
        mask_s  = MASK_ZERO;
        per_s   = PER_ZERO;
        timer_s = PER_ZERO;
        rem_s   = CNT_ZERO;
      end
    endcase
  end

  // state, latched command and registered status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      mask_r  <= MASK_ZERO;
      per_r   <= PER_ZERO;
      timer_r <= PER_ZERO;
      rem_r   <= CNT_ZERO;
      ready_r <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      mask_r  <= mask_s;
      per_r   <= per_s;
      timer_r <= timer_s;
      rem_r   <= rem_s;
      ready_r <= (state_s == ST_IDLE);
      busy_r  <= (state_s != ST_IDLE);
      done_r  <= (state_s == ST_DONE);
    end
  end

  assign cmd_ready = ready_r;
  assign busy      = busy_r;
  assign done      = done_r;

  for (genvar i = 0; i < MASK_W; i++) begin : g_bank
    tff_cell u_cell (
      .clk   (clk),
      .reset (reset),
      .t     (t_out[i]),
      .q     (q[i])
    );
  end

endmodule

// File: tb/tb_tff_seq_ctrl.sv
// Self-checking bench for tff_seq_ctrl: directed table, corner sequences, random vs. schedule model.
module tb_tff_seq_ctrl;
  import tff_seq_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_mask = 8'h00;
  logic [7:0] cmd_count = 8'h00;
  logic [3:0] cmd_period = 4'h0;
`ifdef TFF_SEQ_ABORT_EN
  logic       abort = 1'b0;
`endif
  logic       cmd_ready, busy, done;
  logic [7:0] t_out, q;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tff_seq_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_mask   (cmd_mask),
    .cmd_count  (cmd_count),
    .cmd_period (cmd_period),
`ifdef TFF_SEQ_ABORT_EN
    .abort      (abort),
`endif
    .t_out      (t_out),
    .q          (q),
    .busy       (busy),
    .done       (done)
  );

  tff_seq_ctrl_chk u_chk (
    .clk       (clk),
    .reset     (reset),
    .cmd_ready (cmd_ready),
    .busy      (busy),
    .done      (done),
    .t_out     (t_out)
  );

  typedef struct {
    logic       v;
    logic [7:0] m;
    logic [7:0] c;
    logic [3:0] p;
    logic [18:0] exp;
  } row_t;

  row_t tbl [18];

  function automatic logic [18:0] e(input logic r, input logic b, input logic d,
                                    input logic [7:0] t, input logic [7:0] qq);
    return {r, b, d, t, qq};
  endfunction

  function automatic row_t mk(input logic v, input logic [7:0] m, input logic [7:0] c,
                              input logic [3:0] p, input logic [18:0] x);
    row_t r;
    r.v = v; r.m = m; r.c = c; r.p = p; r.exp = x;
    return r;
  endfunction

  function automatic logic [18:0] outs();
    return {cmd_ready, busy, done, t_out, q};
  endfunction

  task automatic check(input string nm, input logic [18:0] got, input logic [18:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got rdy/busy/done=%b%b%b t_out=%h q=%h, expected %b%b%b t_out=%h q=%h",
               nm, got[18], got[17], got[16], got[15:8], got[7:0],
               exp[18], exp[17], exp[16], exp[15:8], exp[7:0]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] m, input logic [7:0] c, input logic [3:0] p);
    cmd_valid = v; cmd_mask = m; cmd_count = c; cmd_period = p;
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not complete, required finish before 400000");
    $fatal(1);
  end

  initial begin
    int ph, n_s, done_ph, per_m;
    logic [7:0] mask_m, q_m, t_m;
    logic have, active, run, ab;

    // Busy FF command with the command inputs churning, then 0x05 x3 back-to-back, then count=0.
    tbl[0]  = mk(1'b1, 8'hFF, 8'd2, 4'd3, e(1'b1, 1'b0, 1'b0, 8'h00, 8'h00));
    tbl[1]  = mk(1'b1, 8'h3C, 8'd5, 4'd1, e(1'b0, 1'b1, 1'b0, 8'h00, 8'h00));
    tbl[2]  = mk(1'b1, 8'hA5, 8'd0, 4'd0, e(1'b0, 1'b1, 1'b0, 8'h00, 8'h00));
    tbl[3]  = mk(1'b1, 8'h11, 8'd9, 4'd2, e(1'b0, 1'b1, 1'b0, 8'h00, 8'h00));
    tbl[4]  = mk(1'b1, 8'h0F, 8'd1, 4'd0, e(1'b0, 1'b1, 1'b0, 8'hFF, 8'h00));
    tbl[5]  = mk(1'b1, 8'hF0, 8'd3, 4'd7, e(1'b0, 1'b1, 1'b0, 8'h00, 8'hFF));
    tbl[6]  = mk(1'b1, 8'h77, 8'd2, 4'd1, e(1'b0, 1'b1, 1'b0, 8'h00, 8'hFF));
    tbl[7]  = mk(1'b1, 8'h5A, 8'd4, 4'd0, e(1'b0, 1'b1, 1'b0, 8'h00, 8'hFF));
    tbl[8]  = mk(1'b1, 8'hC3, 8'd1, 4'd2, e(1'b0, 1'b1, 1'b0, 8'hFF, 8'hFF));
    tbl[9]  = mk(1'b1, 8'h05, 8'd3, 4'd0, e(1'b0, 1'b1, 1'b1, 8'h00, 8'h00));
    tbl[10] = mk(1'b1, 8'h05, 8'd3, 4'd0, e(1'b1, 1'b0, 1'b0, 8'h00, 8'h00));
    tbl[11] = mk(1'b0, 8'hAA, 8'd7, 4'd5, e(1'b0, 1'b1, 1'b0, 8'h05, 8'h00));
    tbl[12] = mk(1'b0, 8'hAA, 8'd7, 4'd5, e(1'b0, 1'b1, 1'b0, 8'h05, 8'h05));
    tbl[13] = mk(1'b0, 8'hAA, 8'd7, 4'd5, e(1'b0, 1'b1, 1'b0, 8'h05, 8'h00));
    tbl[14] = mk(1'b0, 8'hAA, 8'd7, 4'd5, e(1'b0, 1'b1, 1'b1, 8'h00, 8'h05));
    tbl[15] = mk(1'b1, 8'hFF, 8'd0, 4'd7, e(1'b1, 1'b0, 1'b0, 8'h00, 8'h05));
    tbl[16] = mk(1'b0, 8'h00, 8'd0, 4'd0, e(1'b0, 1'b1, 1'b1, 8'h00, 8'h05));
    tbl[17] = mk(1'b0, 8'h00, 8'd0, 4'd0, e(1'b1, 1'b0, 1'b0, 8'h00, 8'h05));

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", outs(), e(1'b1, 1'b0, 1'b0, 8'h00, 8'h00));
    reset = 1'b0;

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].v, tbl[i].m, tbl[i].c, tbl[i].p);
      #1;
      check($sformatf("table_row%0d", i), outs(), tbl[i].exp);
      step();
    end

    // Reset mid-command after the first of four 0x80 pulses.
    drive(1'b1, 8'h80, 8'd4, 4'd1);
    #1; check("rst_seq_idle", outs(), e(1'b1, 1'b0, 1'b0, 8'h00, 8'h05));
    step(); drive(1'b0, 8'h00, 8'd0, 4'd0);
    #1; check("rst_seq_c1", outs(), e(1'b0, 1'b1, 1'b0, 8'h00, 8'h05));
    step();
    #1; check("rst_seq_c2", outs(), e(1'b0, 1'b1, 1'b0, 8'h80, 8'h05));
    step();
    #1; check("rst_seq_c3", outs(), e(1'b0, 1'b1, 1'b0, 8'h00, 8'h85));
    #2; reset = 1'b1;
    #1; check("rst_mid_run", outs(), e(1'b1, 1'b0, 1'b0, 8'h00, 8'h00));
    step(); reset = 1'b0;
    #1; check("rst_release", outs(), e(1'b1, 1'b0, 1'b0, 8'h00, 8'h00));
    step();
    #1; check("rst_release_hold", outs(), e(1'b1, 1'b0, 1'b0, 8'h00, 8'h00));

`ifdef TFF_SEQ_ABORT_EN
    drive(1'b1, 8'h01, 8'd10, 4'd1);
    #1; check("abort_idle", outs(), e(1'b1, 1'b0, 1'b0, 8'h00, 8'h00));
    step(); drive(1'b0, 8'h00, 8'd0, 4'd0);
    #1; check("abort_c1", outs(), e(1'b0, 1'b1, 1'b0, 8'h00, 8'h00));
    step();
    #1; check("abort_c2", outs(), e(1'b0, 1'b1, 1'b0, 8'h01, 8'h00));
    step();
    #1; check("abort_c3", outs(), e(1'b0, 1'b1, 1'b0, 8'h00, 8'h01));
    step(); abort = 1'b1;
    #1; check("abort_suppress", outs(), e(1'b0, 1'b1, 1'b0, 8'h00, 8'h01));
    step(); abort = 1'b0;
    #1; check("abort_done", outs(), e(1'b0, 1'b1, 1'b1, 8'h00, 8'h01));
    step();
    #1; check("abort_idle_after", outs(), e(1'b1, 1'b0, 1'b0, 8'h00, 8'h01));
`endif

    // Random traffic against a schedule model: pulses at n+p, n+p+(p+1), ...; done at n+c*(p+1).
    reset = 1'b1;
    step();
    reset = 1'b0;
    q_m = 8'h00; have = 1'b0; ph = 0; n_s = 0; done_ph = 0; per_m = 0; mask_m = 8'h00;
    for (int i = 0; i < 3000; i++) begin
      cmd_valid  = ($urandom_range(0, 1) == 1);
      cmd_mask   = 8'($urandom);
      cmd_count  = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 20)) : 8'($urandom_range(0, 4));
      cmd_period = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'($urandom_range(0, 2));
      ab = 1'b0;
`ifdef TFF_SEQ_ABORT_EN
      abort = ($urandom_range(0, 15) == 0);
      ab = abort;
`endif
      #1;
      active = have && (ph >= n_s) && (ph <= done_ph);
      run    = active && (ph < done_ph);
      t_m    = (run && !ab && (((ph - n_s) % (per_m + 1)) == per_m)) ? mask_m : 8'h00;
      check("random", outs(), e(!active, active, active && (ph == done_ph), t_m, q_m));
      q_m = q_m ^ t_m;
      if (run && ab) done_ph = ph + 1;
      if (!active && cmd_valid) begin
        have    = 1'b1;
        n_s     = ph + 1;
        per_m   = int'(cmd_period);
        mask_m  = cmd_mask;
        done_ph = n_s + int'(cmd_count) * (per_m + 1);
      end
      step();
      ph++;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tff_seq_ctrl.md
TFF_SEQ_CTRL -- requirements
Module: tff_seq_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset, with the clock port named clk and the reset port named reset.
REQ-002 SHALL use these ports (name, direction, width, meaning):
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous reset, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command acceptable.
- cmd_mask  in  8  bits to toggle on each pulse.
- cmd_count  in  8  number of toggle pulses.
- cmd_period  in  4  pulse spacing minus 1.
- t_out  out  8  T inputs presented to the internal toggle bank.
- q  out  8  toggle bank state.
- busy  out  1  command in progress.
- done  out  1  one-cycle completion pulse.
- abort  in  1  cancel the current command; present only when TFF_SEQ_ABORT_EN is defined.

Function
REQ-003 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-004 SHALL drive cmd_ready=1 only in IDLE; a command is accepted on a clk edge where cmd_valid && cmd_ready.
REQ-005 SHALL, on acceptance, latch mask, count and period internally; later changes on the cmd_* ports are ignored until the FSM returns to IDLE.
REQ-006 SHALL go IDLE->DONE when the accepted count==0, with no pulse on t_out.
REQ-007 SHALL go IDLE->RUN when the accepted count>0, loading the interval timer with period.
REQ-008 SHALL, in RUN, decrement the timer each cycle; when timer==0, drive t_out=latched mask for exactly that cycle, reload the timer with period, and decrement the remaining count.
REQ-009 SHALL assert the first t_out pulse period+1 cycles after the acceptance edge and space later pulses exactly period+1 cycles apart; period=0 gives back-to-back pulses.
REQ-010 SHALL go RUN->DONE on the cycle after the pulse that takes the remaining count to 0.
REQ-011 SHALL hold DONE for exactly one cycle with done=1, then return to IDLE; a new command is accepted no earlier than the cycle after DONE.
REQ-012 SHALL drive t_out=0 whenever no pulse is active.
REQ-013 SHALL update each q[i] at every clk edge as q[i] <= q[i] ^ t_out[i], so q reflects a pulse one edge after it.
REQ-014 SHALL not reset q between commands; q retains its value across commands.
REQ-015 SHALL drive busy=1 in RUN and DONE, and 0 in IDLE.
REQ-016 SHALL, for mask=0, execute the full timing and done sequence with q unchanged.

Reset
REQ-017 SHALL, on reset assertion at any time including mid-command, immediately force: FSM=IDLE, q=0, t_out=0, done=0, busy=0, timer=0, remaining count=0, latched fields=0.
REQ-018 SHALL drive cmd_ready=1 in the first cycle after reset deasserts.

Configuration
REQ-019 SHALL, with TFF_SEQ_ABORT_EN defined, provide the abort port; abort=1 in RUN forces RUN->DONE on the next edge with no further pulse and q kept; abort in IDLE or DONE is ignored; abort takes priority over a same-cycle pulse, suppressing that pulse.
REQ-020 SHALL, without TFF_SEQ_ABORT_EN, omit the abort port and leave all other behaviour identical.

Structure
REQ-021 SHALL place the FSM state enum typedef, the MASK_W=8, CNT_W=8 and PER_W=4 constants, and the state encodings in the shared package tff_seq_pkg.
REQ-022 SHALL build the toggle bank from 8 instances of sub-module tff_cell (1-bit T flip-flop realised as a D flop with D=T^Q and async active-high reset), with t_out bits driving the T inputs.

Verification
REQ-023 SHALL cover these directed scenarios:
- Mask=0x05, count=3, period=0, q=0x00 -> t_out=0x05 on cycles 1,2,3 after accept; q = 0x05, 0x00, 0x05; done=1 on cycle 4; cmd_ready=1 on cycle 5.
- Mask=0xFF, count=2, period=3 -> pulses on cycles 4 and 8 after accept; final q=0x00; done on cycle 9.
- Count=0, mask=0xFF -> no t_out pulse; done=1 on cycle 1; q unchanged.
- Reset asserted during RUN after 1 of 4 pulses (mask=0x80) -> q=0x00, busy=0 and t_out=0 immediately; cmd_ready=1 after release.
- cmd_valid held with changing cmd_mask during RUN -> no second acceptance; pulses use the latched mask; back-to-back command accepted only after DONE.
- With TFF_SEQ_ABORT_EN: mask=0x01, count=10, period=1, abort on the cycle of the 2nd pulse -> that pulse suppressed; q=0x01; done on the next cycle.
